// File: rtl/regfile_rename.sv
// Architectural register file with per-register ROB rename tags and two combinational read ports.
// Optional RF_RETIRE_CNT_EN adds oRF_retire_cnt, a free-running count of commit writes.
module regfile_rename #(
  parameter int REG_NUM = 32,
  parameter int NICK_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iROB_nick_en,
  input  logic [NICK_W-1:0] iROB_nick,
  input  logic [4:0]        iROB_nick_regnm,
  input  logic              iRF_en,
  input  logic [4:0]        iRF_rd_regnm,
  input  logic [DATA_W-1:0] iRF_rd_dt,
  input  logic [NICK_W-1:0] iRF_rd_nick,
  input  logic [4:0]        iDP_rs1_regnm,
  input  logic [4:0]        iDP_rs2_regnm,
  output logic              oDP_rs1_busy,
  output logic [NICK_W-1:0] oDP_rs1_nick,
  output logic [DATA_W-1:0] oDP_rs1_dt,
  output logic              oDP_rs2_busy,
  output logic [NICK_W-1:0] oDP_rs2_nick,
  output logic [DATA_W-1:0] oDP_rs2_dt
`ifdef RF_RETIRE_CNT_EN
  ,
  output logic [31:0]       oRF_retire_cnt
`endif
);

  typedef struct packed {
    logic              busy;
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
  } rd_t;

  logic [DATA_W-1:0] dt_q  [REG_NUM];
  logic [DATA_W-1:0] dt_d  [REG_NUM];
  logic [NICK_W-1:0] tag_q [REG_NUM];
  logic [NICK_W-1:0] tag_d [REG_NUM];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    dt_d  = dt_q;
    tag_d = tag_q;
    if (rdy) begin
      if (iRF_en && (iRF_rd_regnm != 5'd0)) begin
        dt_d[iRF_rd_regnm] = iRF_rd_dt;
        if ((iRF_rd_nick != '0) && (tag_q[iRF_rd_regnm] == iRF_rd_nick))
          tag_d[iRF_rd_regnm] = '0;
      end
      // Flush beats rename; a rename beats a same-cycle commit clear.
      if (clr) begin
        for (int i = 0; i < REG_NUM; i++) tag_d[i] = '0;
      end else if (iROB_nick_en && (iROB_nick_regnm != 5'd0) && (iROB_nick != '0)) begin
        tag_d[iROB_nick_regnm] = iROB_nick;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        dt_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      dt_q  <= dt_d;
      tag_q <= tag_d;
    end
  end

  function automatic rd_t rd_lookup(input logic [4:0] r);
    rd_t res;
    res = '0;
    if (r == 5'd0) begin
      res = '0;
    end else if (iRF_en && (iRF_rd_regnm == r) && (tag_q[r] == iRF_rd_nick)) begin
      res.dt = iRF_rd_dt;
    end else if (tag_q[r] != '0) begin
      res.busy = 1'b1;
      res.nick = tag_q[r];
    end else begin
      res.dt = dt_q[r];
    end
    return res;
  endfunction

  rd_t rs1_res;
  rd_t rs2_res;

  always_comb begin
    rs1_res      = rd_lookup(iDP_rs1_regnm);
    rs2_res      = rd_lookup(iDP_rs2_regnm);
    oDP_rs1_busy = rs1_res.busy;
    oDP_rs1_nick = rs1_res.nick;
    oDP_rs1_dt   = rs1_res.dt;
    oDP_rs2_busy = rs2_res.busy;
    oDP_rs2_nick = rs2_res.nick;
    oDP_rs2_dt   = rs2_res.dt;
  end

`ifdef RF_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;
  logic [31:0] retire_cnt_d;

  // Counts every commit handshake, x0 included; flush does not reset it.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (rdy && iRF_en) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retire_cnt_q <= '0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign oRF_retire_cnt = retire_cnt_q;
`endif

endmodule
